// File: rtl/axi4lite_master_bridge.sv
// Single-outstanding AXI4-Lite master: turns one READ/WRITE/BOTH command into
// bus traffic and hands the captured bus response back on the rsp_* port.
module axi4lite_master_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [1:0]              rsp_op,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_rresp,
   output logic [1:0]              rsp_bresp,
   output logic [ADDR_WIDTH-1:0]   AWADDR,
   output logic [2:0]              AWPROT,
   output logic                    AWVALID,
   input  logic                    AWREADY,
   output logic [DATA_WIDTH-1:0]   WDATA,
   output logic [DATA_WIDTH/8-1:0] WSTRB,
   output logic                    WVALID,
   input  logic                    WREADY,
   input  logic [1:0]              BRESP,
   input  logic                    BVALID,
   output logic                    BREADY,
   output logic [ADDR_WIDTH-1:0]   ARADDR,
   output logic [2:0]              ARPROT,
   output logic                    ARVALID,
   input  logic                    ARREADY,
   input  logic [DATA_WIDTH-1:0]   RDATA,
   input  logic [1:0]              RRESP,
   input  logic                    RVALID,
   output logic                    RREADY
);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RESP} state_t;

   state_t                  state;
   state_t                  next_state;
   logic [1:0]              op_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    accept;

   assign accept = cmd_valid & cmd_ready;
   assign AWADDR = addr_q;
   assign ARADDR = addr_q;
   assign AWPROT = 3'b000;
   assign ARPROT = 3'b000;
   assign rsp_op = op_q;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state <= IDLE;
      else        state <= next_state;
   end

   // A write channel counts as done once its VALID has dropped or is handshaking now.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
               case (cmd_op)
                  2'd0:       next_state = RD_REQ;
                  2'd1, 2'd2: next_state = WR_REQ;
                  default:    next_state = RESP;
               endcase
            end
         end
         WR_REQ: if ((!AWVALID || AWREADY) && (!WVALID || WREADY)) next_state = WR_RSP;
         WR_RSP: if (BVALID && BREADY) next_state = (op_q == 2'd2) ? RD_REQ : RESP;
         RD_REQ: if (ARVALID && ARREADY) next_state = RD_RSP;
         RD_RSP: if (RVALID && RREADY) next_state = RESP;
         RESP:   if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Handshake outputs are decoded from next_state so they are registered yet line up with the state.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         AWVALID   <= 1'b0;
         WVALID    <= 1'b0;
         BREADY    <= 1'b0;
         ARVALID   <= 1'b0;
         RREADY    <= 1'b0;
         op_q      <= '0;
         addr_q    <= '0;
         WDATA     <= '0;
         WSTRB     <= '0;
         rsp_rdata <= '0;
         rsp_rresp <= '0;
         rsp_bresp <= '0;
      end else begin
         cmd_ready <= (next_state == IDLE);
         rsp_valid <= (next_state == RESP);
         BREADY    <= (next_state == WR_RSP);
         ARVALID   <= (next_state == RD_REQ);
         RREADY    <= (next_state == RD_RSP);

         if (accept && (cmd_op == 2'd1 || cmd_op == 2'd2)) begin
            AWVALID <= 1'b1;
            WVALID  <= 1'b1;
         end else begin
            if (AWVALID && AWREADY) AWVALID <= 1'b0;
            if (WVALID && WREADY)   WVALID  <= 1'b0;
         end

         if (accept) begin
            op_q      <= cmd_op;
            addr_q    <= cmd_addr;
            WDATA     <= cmd_wdata;
            WSTRB     <= cmd_wstrb;
            rsp_rdata <= '0;
            rsp_rresp <= (cmd_op == 2'd3) ? 2'b10 : 2'b00;
            rsp_bresp <= (cmd_op == 2'd3) ? 2'b10 : 2'b00;
         end

         if (state == WR_RSP && BVALID && BREADY) rsp_bresp <= BRESP;

         if (state == RD_RSP && RVALID && RREADY) begin
            rsp_rdata <= RDATA;
            rsp_rresp <= RRESP;
         end
      end
   end

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// Directed bench for axi4lite_master_bridge with a configurable-delay AXI4-Lite slave
// model and a cycle monitor that timestamps every handshake.
module tb_axi4lite_master_bridge;

   logic        ACLK;
   logic        ARESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_op;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_rresp;
   logic [1:0]  rsp_bresp;
   logic [31:0] AWADDR;
   logic [2:0]  AWPROT;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [31:0] ARADDR;
   logic [2:0]  ARPROT;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   int tests = 0;
   int failures = 0;

   int          aw_delay = 0;
   int          w_delay = 0;
   int          ar_delay = 0;
   logic [1:0]  b_resp_k = 2'b00;
   logic [1:0]  r_resp_k = 2'b00;
   logic [31:0] r_data_k = 32'h0;
   logic        b_hold = 1'b0;

   axi4lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
      .rsp_rdata(rsp_rdata), .rsp_rresp(rsp_rresp), .rsp_bresp(rsp_bresp),
      .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   // Slave model: each READY rises after its VALID has waited the configured number of cycles.
   int aw_wait;
   int w_wait;
   int ar_wait;
   logic aw_got;
   logic w_got;

   assign AWREADY = AWVALID && (aw_wait >= aw_delay);
   assign WREADY  = WVALID && (w_wait >= w_delay);
   assign ARREADY = ARVALID && (ar_wait >= ar_delay);

   always @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_wait <= 0;
         w_wait  <= 0;
         ar_wait <= 0;
      end else begin
         aw_wait <= (AWVALID && !AWREADY) ? aw_wait + 1 : 0;
         w_wait  <= (WVALID && !WREADY) ? w_wait + 1 : 0;
         ar_wait <= (ARVALID && !ARREADY) ? ar_wait + 1 : 0;
      end
   end

   always @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_got <= 1'b0;
         w_got  <= 1'b0;
         BVALID <= 1'b0;
         BRESP  <= 2'b00;
      end else begin
         if (BVALID && BREADY) BVALID <= 1'b0;
         if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY)) && !b_hold) begin
            BVALID <= 1'b1;
            BRESP  <= b_resp_k;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end else begin
            if (AWVALID && AWREADY) aw_got <= 1'b1;
            if (WVALID && WREADY)   w_got  <= 1'b1;
         end
      end
   end

   always @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         RVALID <= 1'b0;
         RDATA  <= 32'h0;
         RRESP  <= 2'b00;
      end else if (ARVALID && ARREADY) begin
         RVALID <= 1'b1;
         RDATA  <= r_data_k;
         RRESP  <= r_resp_k;
      end else if (RVALID && RREADY) begin
         RVALID <= 1'b0;
      end
   end

   // Monitor: cycle stamps and cumulative counts; steps take deltas around each command.
   int cyc = 0;
   int acc_cyc = 0;
   int rsp_cyc = 0;
   int aw_hs_cyc = 0;
   int w_hs_cyc = 0;
   int ar_hs_cyc = 0;
   int aw_hs_n = 0;
   int w_hs_n = 0;
   int ar_hs_n = 0;
   int b_hs_n = 0;
   int aw_vcyc = 0;
   int w_vcyc = 0;
   int ar_vcyc = 0;
   int ar_unstable = 0;
   logic        rsp_prev = 1'b0;
   logic        ar_prev_valid = 1'b0;
   logic [31:0] ar_prev_addr = 32'h0;
   logic [31:0] aw_addr_hs = 32'h0;
   logic [31:0] w_data_hs = 32'h0;
   logic [3:0]  w_strb_hs = 4'h0;
   logic [31:0] ar_addr_hs = 32'h0;

   always @(posedge ACLK) begin
      cyc <= cyc + 1;
      rsp_prev <= rsp_valid;
      ar_prev_valid <= ARVALID;
      ar_prev_addr <= ARADDR;
      if (cmd_valid && cmd_ready) acc_cyc <= cyc;
      if (rsp_valid && !rsp_prev) rsp_cyc <= cyc;
      if (AWVALID) aw_vcyc <= aw_vcyc + 1;
      if (WVALID)  w_vcyc  <= w_vcyc + 1;
      if (ARVALID) ar_vcyc <= ar_vcyc + 1;
      if (ARVALID && ar_prev_valid && ARADDR != ar_prev_addr) ar_unstable <= ar_unstable + 1;
      if (AWVALID && AWREADY) begin
         aw_hs_n <= aw_hs_n + 1;
         aw_hs_cyc <= cyc;
         aw_addr_hs <= AWADDR;
      end
      if (WVALID && WREADY) begin
         w_hs_n <= w_hs_n + 1;
         w_hs_cyc <= cyc;
         w_data_hs <= WDATA;
         w_strb_hs <= WSTRB;
      end
      if (ARVALID && ARREADY) begin
         ar_hs_n <= ar_hs_n + 1;
         ar_hs_cyc <= cyc;
         ar_addr_hs <= ARADDR;
      end
      if (BVALID && BREADY) b_hs_n <= b_hs_n + 1;
   end

   int base_aw_n;
   int base_w_n;
   int base_ar_n;
   int base_b_n;
   int base_aw_v;
   int base_w_v;
   int base_ar_v;
   int base_ar_unstable;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Called at a negedge; presents the command for exactly the accepting cycle.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb);
      int n;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge ACLK);
         n++;
      end
      if (!cmd_ready) checkOutput("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
      base_aw_n = aw_hs_n;
      base_w_n = w_hs_n;
      base_ar_n = ar_hs_n;
      base_b_n = b_hs_n;
      base_aw_v = aw_vcyc;
      base_w_v = w_vcyc;
      base_ar_v = ar_vcyc;
      base_ar_unstable = ar_unstable;
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_addr = addr;
      cmd_wdata = wdata;
      cmd_wstrb = wstrb;
      @(negedge ACLK);
      cmd_valid = 1'b0;
      cmd_op = 2'd0;
      cmd_addr = 32'h0;
      cmd_wdata = 32'h0;
      cmd_wstrb = 4'h0;
   endtask

   task automatic waitResponse();
      int n;
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge ACLK);
         n++;
      end
      checkOutput("rsp_valid_arrives", 64'(rsp_valid), 64'd1);
   endtask

   task automatic releaseResponse();
      rsp_ready = 1'b1;
      @(negedge ACLK);
      rsp_ready = 1'b0;
      checkOutput("rsp_valid_drops", 64'(rsp_valid), 64'd0);
      checkOutput("cmd_ready_back", 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      ARESET = 1'b0;
      cmd_valid = 1'b0;
      cmd_op = 2'd0;
      cmd_addr = 32'h0;
      cmd_wdata = 32'h0;
      cmd_wstrb = 4'h0;
      rsp_ready = 1'b0;
      #1 ARESET = 1'b1;

      // Reset state
      repeat (2) @(negedge ACLK);
      checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      checkOutput("rst_handshakes", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}), 64'd0);
      checkOutput("rst_addr_data", 64'({AWADDR, WDATA}), 64'd0);
      checkOutput("rst_rsp_regs", 64'({rsp_rdata, rsp_rresp, rsp_bresp, rsp_op}), 64'd0);
      checkOutput("rst_prot", 64'({AWPROT, ARPROT}), 64'd0);
      ARESET = 1'b0;
      @(negedge ACLK);
      checkOutput("rel_cmd_ready", 64'(cmd_ready), 64'd1);

      // WRITE, zero-wait slave
      applyStimulus(2'd1, 32'h10, 32'hDEADBEEF, 4'hF);
      waitResponse();
      checkOutput("wr_rsp_bresp", 64'(rsp_bresp), 64'd0);
      checkOutput("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
      checkOutput("wr_rsp_op", 64'(rsp_op), 64'd1);
      releaseResponse();
      checkOutput("wr_aw_latency", 64'(aw_hs_cyc - acc_cyc), 64'd1);
      checkOutput("wr_w_latency", 64'(w_hs_cyc - acc_cyc), 64'd1);
      checkOutput("wr_awaddr", 64'(aw_addr_hs), 64'h10);
      checkOutput("wr_wdata", 64'(w_data_hs), 64'hDEADBEEF);
      checkOutput("wr_wstrb", 64'(w_strb_hs), 64'hF);
      checkOutput("wr_rsp_latency", 64'(rsp_cyc - acc_cyc), 64'd3);
      checkOutput("wr_b_count", 64'(b_hs_n - base_b_n), 64'd1);

      // READ with ARREADY held off 3 cycles
      ar_delay = 3;
      r_data_k = 32'h12345678;
      applyStimulus(2'd0, 32'h20, 32'h0, 4'h0);
      waitResponse();
      checkOutput("rd_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
      checkOutput("rd_rsp_resps", 64'({rsp_rresp, rsp_bresp}), 64'd0);
      checkOutput("rd_rsp_op", 64'(rsp_op), 64'd0);
      releaseResponse();
      checkOutput("rd_arvalid_cycles", 64'(ar_vcyc - base_ar_v), 64'd4);
      checkOutput("rd_araddr_stable", 64'(ar_unstable - base_ar_unstable), 64'd0);
      checkOutput("rd_araddr", 64'(ar_addr_hs), 64'h20);
      checkOutput("rd_ar_latency", 64'(ar_hs_cyc - acc_cyc), 64'd4);
      checkOutput("rd_rsp_latency", 64'(rsp_cyc - acc_cyc), 64'd6);
      checkOutput("rd_no_writes", 64'(aw_hs_n - base_aw_n), 64'd0);
      ar_delay = 0;

      // WRITE with WREADY two cycles ahead of AWREADY
      aw_delay = 2;
      applyStimulus(2'd1, 32'h8, 32'h11223344, 4'h3);
      waitResponse();
      checkOutput("split_rsp_bresp", 64'(rsp_bresp), 64'd0);
      releaseResponse();
      repeat (3) @(negedge ACLK);
      checkOutput("split_w_latency", 64'(w_hs_cyc - acc_cyc), 64'd1);
      checkOutput("split_aw_latency", 64'(aw_hs_cyc - acc_cyc), 64'd3);
      checkOutput("split_wvalid_cycles", 64'(w_vcyc - base_w_v), 64'd1);
      checkOutput("split_awvalid_cycles", 64'(aw_vcyc - base_aw_v), 64'd3);
      checkOutput("split_b_count", 64'(b_hs_n - base_b_n), 64'd1);
      checkOutput("split_wstrb", 64'(w_strb_hs), 64'h3);
      checkOutput("split_rsp_latency", 64'(rsp_cyc - acc_cyc), 64'd5);
      aw_delay = 0;

      // BOTH with SLVERR write response; the read-back still runs
      b_resp_k = 2'b10;
      r_data_k = 32'hCAFEF00D;
      applyStimulus(2'd2, 32'h4, 32'hA5A5A5A5, 4'hF);
      waitResponse();
      checkOutput("both_rsp_bresp", 64'(rsp_bresp), 64'd2);
      checkOutput("both_rsp_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
      checkOutput("both_rsp_rresp", 64'(rsp_rresp), 64'd0);
      checkOutput("both_rsp_op", 64'(rsp_op), 64'd2);
      releaseResponse();
      checkOutput("both_rsp_latency", 64'(rsp_cyc - acc_cyc), 64'd5);
      checkOutput("both_ar_count", 64'(ar_hs_n - base_ar_n), 64'd1);
      checkOutput("both_b_count", 64'(b_hs_n - base_b_n), 64'd1);
      checkOutput("both_araddr", 64'(ar_addr_hs), 64'h4);
      checkOutput("both_wdata", 64'(w_data_hs), 64'hA5A5A5A5);
      b_resp_k = 2'b00;

      // Reserved op: immediate error response, no bus activity, stable while stalled
      applyStimulus(2'd3, 32'h40, 32'h0, 4'h0);
      waitResponse();
      checkOutput("rsv_rsp_resps", 64'({rsp_bresp, rsp_rresp}), 64'hA);
      checkOutput("rsv_rsp_rdata", 64'(rsp_rdata), 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge ACLK);
         checkOutput("rsv_hold_stable",
                     64'({rsp_valid, cmd_ready, rsp_op, rsp_bresp, rsp_rresp, rsp_rdata}),
                     64'({1'b1, 1'b0, 2'd3, 2'b10, 2'b10, 32'h0}));
      end
      releaseResponse();
      checkOutput("rsv_rsp_latency", 64'(rsp_cyc - acc_cyc), 64'd1);
      checkOutput("rsv_no_valids",
                  64'((aw_vcyc - base_aw_v) + (w_vcyc - base_w_v) + (ar_vcyc - base_ar_v)), 64'd0);

      // Reset asserted while waiting for B
      b_hold = 1'b1;
      applyStimulus(2'd1, 32'h50, 32'h55AA55AA, 4'hF);
      n = 0;
      while (!BREADY && n < 50) begin
         @(negedge ACLK);
         n++;
      end
      checkOutput("mid_reached_wr_rsp", 64'(BREADY), 64'd1);
      #2 ARESET = 1'b1;
      #1;
      checkOutput("mid_rst_handshakes", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid}), 64'd0);
      checkOutput("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
      checkOutput("mid_rst_awaddr", 64'(AWADDR), 64'd0);
      @(negedge ACLK);
      ARESET = 1'b0;
      b_hold = 1'b0;
      @(negedge ACLK);
      checkOutput("mid_rel_cmd_ready", 64'(cmd_ready), 64'd1);

      r_data_k = 32'h0BADF00D;
      applyStimulus(2'd0, 32'h30, 32'h0, 4'h0);
      waitResponse();
      checkOutput("post_rd_rdata", 64'(rsp_rdata), 64'h0BADF00D);
      checkOutput("post_rd_resps", 64'({rsp_rresp, rsp_bresp, rsp_op}), 64'd0);
      releaseResponse();
      checkOutput("post_rd_latency", 64'(rsp_cyc - acc_cyc), 64'd3);
      checkOutput("post_rd_araddr", 64'(ar_addr_hs), 64'h30);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/axi4lite_master_bridge.md
# axi4lite_master_bridge

Converts one command (READ, WRITE or BOTH) into AXI4-Lite master channel traffic and returns the bus response on a response port. It sits between the command source (generator/driver side) and the AXI4-Lite slave under test. It issues one outstanding transaction at a time. BOTH means a write followed by a read-back of the same address.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of cmd_addr, AWADDR and ARADDR.
- DATA_WIDTH, 32, data width; must be 32 or 64. Strobe width is DATA_WIDTH/8.

Ports:
- ACLK  in  1  single clock; all logic is rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both this and cmd_valid are high.
- cmd_op  in  2  0=READ, 1=WRITE, 2=BOTH, 3=reserved.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when both this and rsp_valid are high.
- rsp_op  out  2  echo of the accepted cmd_op.
- rsp_rdata  out  DATA_WIDTH  captured RDATA; 0 for WRITE.
- rsp_rresp, rsp_bresp  out  2 each  captured RRESP and BRESP; 0 when the phase did not run.
- AWADDR, AWPROT, AWVALID, AWREADY  out/out(3)/out/in  write address channel; AWPROT is tied to 3'b000.
- WDATA, WSTRB, WVALID, WREADY  out/out/out/in  write data channel.
- BRESP, BVALID, BREADY  in(2)/in/out  write response channel.
- ARADDR, ARPROT, ARVALID, ARREADY  out/out(3)/out/in  read address channel; ARPROT is tied to 3'b000.
- RDATA, RRESP, RVALID, RREADY  in/in(2)/in/out  read data channel.

## Operation
- FSM states: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RESP.
- IDLE
  - cmd_ready=1 only in this state.
  - On accept, the block registers op, addr, wdata and wstrb, and clears rsp_rdata, rsp_rresp and rsp_bresp.
  - Next state by op: READ→RD_REQ, WRITE or BOTH→WR_REQ, reserved→RESP.
  - For reserved op, rsp_rresp and rsp_bresp are both 2'b10 and no bus activity occurs.
- WR_REQ
  - AWVALID and WVALID rise together on entry.
  - Each VALID drops in the cycle after its own handshake; the two are independent and may complete in either order or in the same cycle.
  - Exit to WR_RSP in the cycle after both handshakes have occurred.
- WR_RSP: BREADY=1. On BVALID, capture BRESP; go to RD_REQ if op is BOTH, else RESP.
- RD_REQ: ARVALID=1 with ARADDR=registered addr; on ARREADY go to RD_RSP.
- RD_RSP: RREADY=1; on RVALID, capture RDATA and RRESP and go to RESP.
- RESP: rsp_valid=1, outputs stable; on rsp_ready go to IDLE.
- BOTH continues to the read phase even if BRESP is non-OKAY.
- All AXI outputs are registered.
- AWADDR, WDATA, WSTRB and ARADDR hold the registered command values from accept until the next accept.
- Once a VALID is raised, it is never withdrawn before its handshake.

## Timing
- Reset (async assert, sync release):
  - state=IDLE.
  - cmd_ready=1 after release; 0 while ARESET is high.
  - All VALID/READY outputs are 0; rsp_valid=0.
  - All address/data/response registers are 0.
- Reset mid-transaction aborts immediately with no completion. The bench resets the slave together with the block.
- Each state transition takes effect the cycle after the qualifying handshake.
- Zero-wait slave (READY always high, response valid the cycle after the request handshake):
  - READ: accept at T, AR at T+1, R at T+2, rsp_valid at T+3.
  - WRITE: accept at T, AW and W at T+1, B at T+2, rsp_valid at T+3.
  - BOTH: rsp_valid at T+5.
  - RESP→IDLE takes 1 cycle, so the next cmd accept is possible no earlier than the cycle after the rsp handshake.
- Reserved op: rsp_valid at T+1.
- No combinational path from any input to any output.

## Test plan
- WRITE addr=0x10, wdata=0xDEADBEEF, wstrb=0xF, zero-wait slave, BRESP=0 -> AW/W handshake at T+1 with matching values; rsp_valid at T+3 with rsp_bresp=0 and rsp_rdata=0.
- READ addr=0x20, slave RDATA=0x12345678, RRESP=0, ARREADY delayed 3 cycles -> ARVALID held 4 cycles with ARADDR stable; rsp_rdata=0x12345678.
- WRITE with WREADY 2 cycles before AWREADY -> WVALID drops after its handshake while AWVALID stays high until its own; exactly one B handshake follows.
- BOTH addr=0x4, wdata=0xA5A5A5A5, BRESP=2'b10 -> read phase still runs; rsp_bresp=2'b10, rsp_rdata equals slave read data, rsp_op=2.
- Reserved op (3) -> no VALID on any channel; rsp_valid at T+1 with rsp_bresp=rsp_rresp=2'b10. Holding rsp_ready low for 5 cycles keeps all rsp outputs stable and cmd_ready=0.
- ARESET pulsed while in WR_RSP -> all VALID/READY and rsp_valid go 0 asynchronously; cmd_ready=1 after release; the next READ completes normally.
